// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//
// Bank of NUM_CH self-incrementing event counters used for pipeline and cache
// statistics (branches, mispredicts, stalls, L1/L2/evict hits and misses).
// Each channel has a sticky overflow flag and either saturates at all-ones or
// wraps to zero. A snapshot copies every live counter and flag into a shadow
// bank in one cycle, so software reads a coherent set of values through the
// indexed, registered readout port while the live counters keep running.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset (live, shadow and outputs to 0)
//   count_en   global increment enable; event strobes ignored while low
//   event_inc  per-channel increment strobe, +1 per cycle while high
//   clear      synchronous clear of all live counters and live overflow flags
//   wr_en      preload one live counter with wr_data
//   wr_idx     channel to preload (indices >= NUM_CH are ignored)
//   wr_data    preload value
//   snapshot   copy live counters and flags into the shadow bank
//   rd_idx     shadow channel to read
//   rd_data    registered shadow count of rd_idx (0 when rd_idx >= NUM_CH)
//   rd_ovf     registered shadow overflow flag of rd_idx
//   ovf_any    registered OR of all live overflow flags
// -----------------------------------------------------------------------------
module perf_counter_bank #(
    parameter int NUM_CH   = 10,
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1,
    parameter int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              count_en,
    input  logic [NUM_CH-1:0] event_inc,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              snapshot,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_ovf,
    output logic              ovf_any
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Live counters and their sticky overflow flags.
    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    // Shadow bank, written only by snapshot.
    logic [WIDTH-1:0]  shadow_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] shadow_ovf_q;

    // Combinational readout selection ahead of the output register.
    logic [WIDTH-1:0]  rd_sel;
    logic              rd_sel_ovf;

    // -------------------------------------------------------------------------
    // Per-channel next state. Priority: clear, then preload, then increment.
    // A preload to a channel swallows that channel's same-cycle strobe.
    // -------------------------------------------------------------------------
    always_comb begin : next_state
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every output of a combinational block gets a default before
            // any condition, otherwise a missing branch infers a latch.
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];

            if (clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                // Out-of-range wr_idx never matches any channel, so it is ignored.
                cnt_d[i] = wr_data;
            end else if (count_en && event_inc[i]) begin
                if (cnt_q[i] != ALL_ONES) begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end else begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = SATURATE ? ALL_ONES : '0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Live counter state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : live_regs
        if (!rst_n) begin
            // NOTE: these arrays are counter registers, not RAM; a reset must
            // discard every count, so each entry is reset explicitly.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow bank. It samples cnt_q/ovf_q (pre-update values), which gives an
    // atomic read-and-reset when snapshot and clear arrive together.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : shadow_regs
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_cnt_q[i] <= '0;
            end
            shadow_ovf_q <= '0;
        end else if (snapshot) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_cnt_q[i] <= cnt_q[i];
            end
            shadow_ovf_q <= ovf_q;
        end
    end

    // -------------------------------------------------------------------------
    // Readout select. Written as a compare-per-channel so an index beyond
    // NUM_CH falls through to zero instead of addressing past the array.
    // -------------------------------------------------------------------------
    always_comb begin : read_select
        rd_sel     = '0;
        rd_sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_sel     = shadow_cnt_q[i];
                rd_sel_ovf = shadow_ovf_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs. rd_data/rd_ovf reflect the shadow bank as it stood
    // before this edge; ovf_any trails the live flags by one cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : out_regs
        if (!rst_n) begin
            rd_data <= '0;
            rd_ovf  <= 1'b0;
            ovf_any <= 1'b0;
        end else begin
            rd_data <= rd_sel;
            rd_ovf  <= rd_sel_ovf;
            ovf_any <= |ovf_q;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_bank
//
// Drives two instances from one stimulus stream: a 16-bit saturating bank and
// an 8-bit wrapping bank (wr_data low byte). A behavioural model of counts and
// flags predicts each cycle's readout; the driver pushes the prediction into a
// queue at the clock edge and an independent monitor pops and compares on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_perf_counter_bank;

    localparam int NUM_CH = 10;
    localparam int IDX_W  = 4;
    localparam int NK     = 2;   // model slot 0: 16-bit saturating, 1: 8-bit wrapping

    logic              clk = 1'b0;
    logic              rst_n;
    logic              count_en;
    logic [NUM_CH-1:0] event_inc;
    logic              clear;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [15:0]       wr_data;
    logic              snapshot;
    logic [IDX_W-1:0]  rd_idx;

    logic [15:0]       rd_data_w;
    logic              rd_ovf_w;
    logic              ovf_any_w;
    logic [7:0]        rd_data_n;
    logic              rd_ovf_n;
    logic              ovf_any_n;

    perf_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(16), .SATURATE(1'b1)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_en  (count_en),
        .event_inc (event_inc),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .snapshot  (snapshot),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data_w),
        .rd_ovf    (rd_ovf_w),
        .ovf_any   (ovf_any_w)
    );

    perf_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(8), .SATURATE(1'b0)) u_dut_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_en  (count_en),
        .event_inc (event_inc),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data[7:0]),
        .snapshot  (snapshot),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data_n),
        .rd_ovf    (rd_ovf_n),
        .ovf_any   (ovf_any_n)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- scoring
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned d0;
        bit          o0;
        bit          a0;
        int unsigned d1;
        bit          o1;
        bit          a1;
    } exp_t;

    exp_t sb_q[$];

    // ---------------------------------------------------------------- model
    int unsigned m_cnt [NK][NUM_CH];
    bit          m_ovf [NK][NUM_CH];
    int unsigned m_sh  [NK][NUM_CH];
    bit          m_sho [NK][NUM_CH];

    function automatic int unsigned max_of(input int k);
        return (k == 0) ? 32'h0000_FFFF : 32'h0000_00FF;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[k][i] = 0;
                m_ovf[k][i] = 1'b0;
                m_sh[k][i]  = 0;
                m_sho[k][i] = 1'b0;
            end
        end
    endfunction

    // What the readout port shows after the coming edge: shadow as it is now,
    // and the OR of live flags as they are now.
    function automatic exp_t predict();
        exp_t e;
        int unsigned d[NK];
        bit          o[NK];
        bit          a[NK];
        for (int k = 0; k < NK; k++) begin
            d[k] = 0;
            o[k] = 1'b0;
            a[k] = 1'b0;
            if (int'(rd_idx) < NUM_CH) begin
                d[k] = m_sh[k][rd_idx];
                o[k] = m_sho[k][rd_idx];
            end
            for (int i = 0; i < NUM_CH; i++) a[k] = a[k] | m_ovf[k][i];
        end
        e.d0 = d[0]; e.o0 = o[0]; e.a0 = a[0];
        e.d1 = d[1]; e.o1 = o[1]; e.a1 = a[1];
        return e;
    endfunction

    function automatic void model_step();
        for (int k = 0; k < NK; k++) begin
            if (snapshot) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    m_sh[k][i]  = m_cnt[k][i];
                    m_sho[k][i] = m_ovf[k][i];
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear) begin
                    m_cnt[k][i] = 0;
                    m_ovf[k][i] = 1'b0;
                end else if (wr_en && int'(wr_idx) == i) begin
                    m_cnt[k][i] = int'(wr_data) & max_of(k);
                end else if (count_en && event_inc[i]) begin
                    if (m_cnt[k][i] == max_of(k)) begin
                        m_ovf[k][i] = 1'b1;
                        m_cnt[k][i] = (k == 0) ? max_of(k) : 0;
                    end else begin
                        m_cnt[k][i] = m_cnt[k][i] + 1;
                    end
                end
            end
        end
    endfunction

    // ---------------------------------------------------------------- driver helpers
    task automatic idle();
        count_en  = 1'b0;
        event_inc = '0;
        clear     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        snapshot  = 1'b0;
    endtask

    // Apply the current inputs for one clock edge and queue the prediction.
    task automatic cycle();
        exp_t e;
        e = predict();
        model_step();
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic preload(input int ch, input logic [15:0] val);
        idle();
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(ch);
        wr_data = val;
        cycle();
        idle();
    endtask

    // Snapshot, then sweep every channel plus one out-of-range index.
    task automatic read_all();
        idle();
        snapshot = 1'b1;
        cycle();
        snapshot = 1'b0;
        for (int r = 0; r < NUM_CH; r++) begin
            rd_idx = IDX_W'(r);
            cycle();
        end
        rd_idx = IDX_W'(15);
        cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data_w16"}, 32'(rd_data_w), 0);
        check({tag, "_rd_ovf_w16"},  32'(rd_ovf_w),  0);
        check({tag, "_ovf_any_w16"}, 32'(ovf_any_w), 0);
        check({tag, "_rd_data_w8"},  32'(rd_data_n), 0);
        check({tag, "_rd_ovf_w8"},   32'(rd_ovf_n),  0);
        check({tag, "_ovf_any_w8"},  32'(ovf_any_n), 0);
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rd_data_w16", 32'(rd_data_w), e.d0);
                check("rd_ovf_w16",  32'(rd_ovf_w),  32'(e.o0));
                check("ovf_any_w16", 32'(ovf_any_w), 32'(e.a0));
                check("rd_data_w8",  32'(rd_data_n), e.d1);
                check("rd_ovf_w8",   32'(rd_ovf_n),  32'(e.o1));
                check("ovf_any_w8",  32'(ovf_any_n), 32'(e.a1));
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : driver
        rst_n  = 1'b0;
        rd_idx = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Five events on channel 0, then read every channel.
        count_en  = 1'b1;
        event_inc = NUM_CH'(1);
        repeat (5) cycle();
        read_all();

        // Overflow on channel 3 from a preload of 0xFE / 0xFFFE.
        preload(3, 16'hFFFE);
        count_en     = 1'b1;
        event_inc[3] = 1'b1;
        repeat (3) cycle();
        idle();
        cycle();
        read_all();

        // Atomic read-and-reset with a same-cycle strobe on channel 2.
        preload(2, 16'd7);
        count_en     = 1'b1;
        event_inc[2] = 1'b1;
        snapshot     = 1'b1;
        clear        = 1'b1;
        cycle();
        idle();
        rd_idx = IDX_W'(2);
        cycle();
        cycle();
        snapshot = 1'b1;
        cycle();
        snapshot = 1'b0;
        cycle();
        cycle();

        // Preload wins over a same-cycle strobe; clear wins over preload.
        idle();
        count_en     = 1'b1;
        event_inc[1] = 1'b1;
        wr_en        = 1'b1;
        wr_idx       = IDX_W'(1);
        wr_data      = 16'h0100;
        cycle();
        read_all();
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(1);
        wr_data = 16'h0055;
        cycle();
        read_all();

        // Global enable low: strobes ignored; out-of-range preload ignored.
        preload(4, 16'd123);
        preload(7, 16'h00FF);
        preload(12, 16'h4444);
        event_inc = '1;
        repeat (10) cycle();
        read_all();

        // Mid-count reset: ch0 at 40, ch5 overflowed, then asynchronous reset.
        preload(5, 16'hFFFF);
        count_en     = 1'b1;
        event_inc[5] = 1'b1;
        cycle();
        preload(0, 16'd30);
        count_en     = 1'b1;
        event_inc[0] = 1'b1;
        repeat (10) cycle();
        idle();
        cycle();
        snapshot = 1'b1;
        rd_idx   = '0;
        cycle();
        snapshot = 1'b0;
        cycle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        read_all();

        // Randomised traffic with values biased toward the overflow boundary.
        for (int n = 0; n < 400; n++) begin
            count_en  = ($urandom_range(0, 3) != 0);
            event_inc = NUM_CH'($urandom);
            clear     = ($urandom_range(0, 31) == 0);
            wr_en     = ($urandom_range(0, 9) == 0);
            wr_idx    = IDX_W'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       wr_data = 16'($urandom);
                1:       wr_data = 16'hFFFC + 16'($urandom_range(0, 3));
                2:       wr_data = 16'h00FC + 16'($urandom_range(0, 3));
                default: wr_data = 16'($urandom_range(0, 15));
            endcase
            snapshot  = ($urandom_range(0, 6) == 0);
            rd_idx    = IDX_W'($urandom_range(0, 15));
            cycle();
        end
        idle();
        cycle();

        // Every queued prediction must be consumed within a few cycles.
        for (int t = 0; t < 5 && sb_q.size() > 0; t++) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
